// File: rtl/store_drain_unit_pkg.sv
// store_drain_unit_pkg: shared store-entry type, drain FSM states and byte-merge helper
package store_drain_unit_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0]   addr;
        logic [SB_DATA_W-1:0]   data;
        logic [SB_DATA_W/8-1:0] strb;
        logic                   valid;
        logic                   commit;
        logic                   complete;
    } sb_entry_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} drain_state_e;

    // Bytes of new_w selected by strb replace the matching bytes of old_w.
    function automatic logic [SB_DATA_W-1:0] merge_bytes(
        input logic [SB_DATA_W-1:0]   old_w,
        input logic [SB_DATA_W-1:0]   new_w,
        input logic [SB_DATA_W/8-1:0] strb
    );
        logic [SB_DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < SB_DATA_W/8; i++)
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/store_drain_unit.sv
// store_drain_unit: drains committed store entries one at a time into single-word dcache writes.
//   clk, rst_n (async, active-low)
//   sb_entry_valid/ready     entry handshake; sb_entry_addr/data/strb/vld are the entry fields
//   wr_req_valid_o/ready_i   write request handshake; wr_req_addr_o/data_o/strb_o from hold register
//   wr_resp_valid_i/err_i    write response pulse and its error flag
//   busy_o                   FSM not idle
//   store_err_o              one-cycle pulse after an error response
//   drain_cnt_o              completed write responses, wraps silently
//   Macro STORE_DRAIN_MERGE_EN: same-word entries arriving while a request stalls are merged into it.
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sb_entry_valid,
    output logic                sb_entry_ready,
    input  logic [ADDR_W-1:0]   sb_entry_addr,
    input  logic [DATA_W-1:0]   sb_entry_data,
    input  logic [DATA_W/8-1:0] sb_entry_strb,
    input  logic                sb_entry_vld,
    output logic                wr_req_valid_o,
    input  logic                wr_req_ready_i,
    output logic [ADDR_W-1:0]   wr_req_addr_o,
    output logic [DATA_W-1:0]   wr_req_data_o,
    output logic [DATA_W/8-1:0] wr_req_strb_o,
    input  logic                wr_resp_valid_i,
    input  logic                wr_resp_err_i,
    output logic                busy_o,
    output logic                store_err_o,
    output logic [CNT_W-1:0]    drain_cnt_o
);

    drain_state_e        state, state_nxt;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_data;
    logic [DATA_W/8-1:0] hold_strb;
    logic                merge;
    logic                resp;

`ifdef STORE_DRAIN_MERGE_EN
    // A merge is refused in the cycle the request is taken, so the sent word never changes under it.
    assign merge = state == REQ && sb_entry_valid && sb_entry_vld && !wr_req_ready_i &&
                   sb_entry_addr[ADDR_W-1:2] == hold_addr[ADDR_W-1:2];
`else
    assign merge = 1'b0;
`endif

    assign resp           = state == WAIT && wr_resp_valid_i;
    assign busy_o         = state != IDLE;
    assign wr_req_addr_o  = hold_addr;
    assign wr_req_data_o  = hold_data;
    assign wr_req_strb_o  = hold_strb;

    always_comb begin
        state_nxt      = state;
        sb_entry_ready = 1'b0;
        wr_req_valid_o = 1'b0;
        case (state)
            IDLE: begin
                sb_entry_ready = 1'b1;
                if (sb_entry_valid && sb_entry_vld && |sb_entry_strb) state_nxt = REQ;
            end
            REQ: begin
                wr_req_valid_o = 1'b1;
                sb_entry_ready = merge;
                if (wr_req_ready_i) state_nxt = WAIT;
            end
            WAIT: if (wr_resp_valid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_addr   <= '0;
            hold_data   <= '0;
            hold_strb   <= '0;
            store_err_o <= 1'b0;
            drain_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            store_err_o <= resp && wr_resp_err_i;
            if (resp) drain_cnt_o <= drain_cnt_o + CNT_W'(1);
            // Dropped entries are still latched; harmless since IDLE never drives a request.
            if (state == IDLE && sb_entry_valid) begin
                hold_addr <= sb_entry_addr & ~ADDR_W'(3);
                hold_data <= sb_entry_data;
                hold_strb <= sb_entry_strb;
            end else if (merge) begin
                hold_data <= merge_bytes(hold_data, sb_entry_data, sb_entry_strb);
                hold_strb <= hold_strb | sb_entry_strb;
            end
        end
    end

endmodule

// File: tb/tb_store_drain_unit.sv
// tb_store_drain_unit: directed self-checking bench for store_drain_unit (merge scenario under STORE_DRAIN_MERGE_EN)
module tb_store_drain_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sb_entry_valid = 1'b0;
    logic        sb_entry_ready;
    logic [31:0] sb_entry_addr = '0;
    logic [31:0] sb_entry_data = '0;
    logic [3:0]  sb_entry_strb = '0;
    logic        sb_entry_vld = 1'b0;
    logic        wr_req_valid_o;
    logic        wr_req_ready_i = 1'b0;
    logic [31:0] wr_req_addr_o;
    logic [31:0] wr_req_data_o;
    logic [3:0]  wr_req_strb_o;
    logic        wr_resp_valid_i = 1'b0;
    logic        wr_resp_err_i = 1'b0;
    logic        busy_o;
    logic        store_err_o;
    logic [15:0] drain_cnt_o;

    int checks = 0;
    int failures = 0;

    store_drain_unit dut (
        .clk(clk), .rst_n(rst_n),
        .sb_entry_valid(sb_entry_valid), .sb_entry_ready(sb_entry_ready),
        .sb_entry_addr(sb_entry_addr), .sb_entry_data(sb_entry_data),
        .sb_entry_strb(sb_entry_strb), .sb_entry_vld(sb_entry_vld),
        .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
        .wr_req_addr_o(wr_req_addr_o), .wr_req_data_o(wr_req_data_o), .wr_req_strb_o(wr_req_strb_o),
        .wr_resp_valid_i(wr_resp_valid_i), .wr_resp_err_i(wr_resp_err_i),
        .busy_o(busy_o), .store_err_o(store_err_o), .drain_cnt_o(drain_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic v);
        sb_entry_valid = 1'b1;
        sb_entry_addr  = a;
        sb_entry_data  = d;
        sb_entry_strb  = s;
        sb_entry_vld   = v;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (sb_entry_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", sb_entry_ready); end
        checks++; if (wr_req_valid_o !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", wr_req_valid_o); end
        checks++; if (drain_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", drain_cnt_o); end
        checks++; if (store_err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", store_err_o); end
        checks++; if ({wr_req_addr_o, wr_req_data_o, wr_req_strb_o} !== 68'd0) begin failures++; $display("FAIL reset_hold: got %h want 0", {wr_req_addr_o, wr_req_data_o, wr_req_strb_o}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive_entry(32'h1000_0006, 32'hAABB_CCDD, 4'b1100, 1'b1);
        checks++; if (sb_entry_ready !== 1'b1) begin failures++; $display("FAIL single_accept_ready: got %b want 1", sb_entry_ready); end
        tick();
        sb_entry_valid = 1'b0;
        checks++; if (wr_req_valid_o !== 1'b1) begin failures++; $display("FAIL single_req_valid: got %b want 1", wr_req_valid_o); end
        checks++; if (wr_req_addr_o !== 32'h1000_0004) begin failures++; $display("FAIL single_addr: got %h want 10000004", wr_req_addr_o); end
        checks++; if (wr_req_data_o !== 32'hAABB_CCDD) begin failures++; $display("FAIL single_data: got %h want aabbccdd", wr_req_data_o); end
        checks++; if (wr_req_strb_o !== 4'b1100) begin failures++; $display("FAIL single_strb: got %b want 1100", wr_req_strb_o); end
        checks++; if (sb_entry_ready !== 1'b0) begin failures++; $display("FAIL single_req_ready: got %b want 0", sb_entry_ready); end
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        checks++; if (wr_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL single_wait: got valid=%b busy=%b want valid=0 busy=1", wr_req_valid_o, busy_o); end
        checks++; if (sb_entry_ready !== 1'b0) begin failures++; $display("FAIL single_wait_ready: got %b want 0", sb_entry_ready); end
        wr_resp_valid_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        checks++; if (drain_cnt_o !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d want 1", drain_cnt_o); end
        checks++; if (sb_entry_ready !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL single_idle: got ready=%b busy=%b want ready=1 busy=0", sb_entry_ready, busy_o); end
        checks++; if (store_err_o !== 1'b0) begin failures++; $display("FAIL single_err: got %b want 0", store_err_o); end
    endtask

    task automatic test_stall();
        drive_entry(32'h0000_0123, 32'h1234_5678, 4'b0011, 1'b1);
        tick();
        sb_entry_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_req_valid_o !== 1'b1 || wr_req_addr_o !== 32'h0000_0120 || wr_req_data_o !== 32'h1234_5678 ||
                wr_req_strb_o !== 4'b0011 || sb_entry_ready !== 1'b0)
            begin
                failures++;
                $display("FAIL stall_cycle%0d: got v=%b a=%h d=%h s=%b rdy=%b want v=1 a=00000120 d=12345678 s=0011 rdy=0",
                         i, wr_req_valid_o, wr_req_addr_o, wr_req_data_o, wr_req_strb_o, sb_entry_ready);
            end
            tick();
        end
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        wr_resp_valid_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        checks++; if (drain_cnt_o !== 16'd2) begin failures++; $display("FAIL stall_cnt: got %0d want 2", drain_cnt_o); end
    endtask

    task automatic test_drop();
        drive_entry(32'h0000_0200, 32'hDEAD_BEEF, 4'b0000, 1'b1);
        tick();
        sb_entry_valid = 1'b0;
        checks++; if (busy_o !== 1'b0 || wr_req_valid_o !== 1'b0 || sb_entry_ready !== 1'b1) begin failures++; $display("FAIL drop_strb0: got busy=%b v=%b rdy=%b want 0 0 1", busy_o, wr_req_valid_o, sb_entry_ready); end
        drive_entry(32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 1'b0);
        tick();
        sb_entry_valid = 1'b0;
        checks++; if (busy_o !== 1'b0 || wr_req_valid_o !== 1'b0 || sb_entry_ready !== 1'b1) begin failures++; $display("FAIL drop_vld0: got busy=%b v=%b rdy=%b want 0 0 1", busy_o, wr_req_valid_o, sb_entry_ready); end
        checks++; if (drain_cnt_o !== 16'd2) begin failures++; $display("FAIL drop_cnt: got %0d want 2", drain_cnt_o); end
    endtask

    task automatic test_error();
        drive_entry(32'h0000_0400, 32'h0000_0011, 4'b0001, 1'b1);
        tick();
        sb_entry_valid = 1'b0;
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        wr_resp_valid_i = 1'b1;
        wr_resp_err_i = 1'b1;
        checks++; if (store_err_o !== 1'b0) begin failures++; $display("FAIL error_early: got %b want 0", store_err_o); end
        tick();
        wr_resp_valid_i = 1'b0;
        wr_resp_err_i = 1'b0;
        checks++; if (store_err_o !== 1'b1) begin failures++; $display("FAIL error_pulse: got %b want 1", store_err_o); end
        checks++; if (drain_cnt_o !== 16'd3) begin failures++; $display("FAIL error_cnt: got %0d want 3", drain_cnt_o); end
        drive_entry(32'h0000_0500, 32'h2200_0000, 4'b1000, 1'b1);
        checks++; if (sb_entry_ready !== 1'b1) begin failures++; $display("FAIL error_next_ready: got %b want 1", sb_entry_ready); end
        tick();
        sb_entry_valid = 1'b0;
        checks++; if (store_err_o !== 1'b0) begin failures++; $display("FAIL error_pulse_len: got %b want 0", store_err_o); end
        checks++; if (wr_req_valid_o !== 1'b1 || wr_req_addr_o !== 32'h0000_0500) begin failures++; $display("FAIL error_next_req: got v=%b a=%h want v=1 a=00000500", wr_req_valid_o, wr_req_addr_o); end
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        wr_resp_valid_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        checks++; if (drain_cnt_o !== 16'd4) begin failures++; $display("FAIL error_next_cnt: got %0d want 4", drain_cnt_o); end
    endtask

    task automatic test_stray_resp();
        wr_resp_valid_i = 1'b1;
        wr_resp_err_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        wr_resp_err_i = 1'b0;
        checks++; if (drain_cnt_o !== 16'd4 || store_err_o !== 1'b0) begin failures++; $display("FAIL stray_resp: got cnt=%0d err=%b want cnt=4 err=0", drain_cnt_o, store_err_o); end
    endtask

    task automatic test_reset_mid();
        drive_entry(32'h0000_0600, 32'h5555_AAAA, 4'b1111, 1'b1);
        tick();
        sb_entry_valid = 1'b0;
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %b want 1", busy_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || drain_cnt_o !== 16'd0) begin failures++; $display("FAIL midrst_async: got busy=%b cnt=%0d want 0 0", busy_o, drain_cnt_o); end
        checks++; if (sb_entry_ready !== 1'b1 || wr_req_valid_o !== 1'b0 || wr_req_addr_o !== 32'd0) begin failures++; $display("FAIL midrst_outs: got rdy=%b v=%b a=%h want 1 0 0", sb_entry_ready, wr_req_valid_o, wr_req_addr_o); end
        tick();
        rst_n = 1'b1;
        wr_resp_valid_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        checks++; if (drain_cnt_o !== 16'd0 || store_err_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL midrst_late_resp: got cnt=%0d err=%b busy=%b want 0 0 0", drain_cnt_o, store_err_o, busy_o); end
    endtask

`ifdef STORE_DRAIN_MERGE_EN
    task automatic test_merge();
        drive_entry(32'h0000_2000, 32'h0000_00EE, 4'b0001, 1'b1);
        tick();
        drive_entry(32'h0000_2002, 32'h00FF_0000, 4'b0100, 1'b1);
        checks++; if (sb_entry_ready !== 1'b1) begin failures++; $display("FAIL merge_ready: got %b want 1", sb_entry_ready); end
        tick();
        drive_entry(32'h0000_2004, 32'h7700_0000, 4'b1000, 1'b1);
        checks++; if (sb_entry_ready !== 1'b0) begin failures++; $display("FAIL merge_other_word: got %b want 0", sb_entry_ready); end
        checks++; if (wr_req_addr_o !== 32'h0000_2000 || wr_req_data_o !== 32'h00FF_00EE || wr_req_strb_o !== 4'b0101) begin failures++; $display("FAIL merge_word: got a=%h d=%h s=%b want 00002000 00ff00ee 0101", wr_req_addr_o, wr_req_data_o, wr_req_strb_o); end
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        checks++; if (sb_entry_ready !== 1'b0) begin failures++; $display("FAIL merge_wait_ready: got %b want 0", sb_entry_ready); end
        wr_resp_valid_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        checks++; if (sb_entry_ready !== 1'b1 || drain_cnt_o !== 16'd1) begin failures++; $display("FAIL merge_one_write: got rdy=%b cnt=%0d want 1 1", sb_entry_ready, drain_cnt_o); end
        tick();
        sb_entry_valid = 1'b0;
        checks++; if (wr_req_addr_o !== 32'h0000_2004 || wr_req_strb_o !== 4'b1000 || wr_req_valid_o !== 1'b1) begin failures++; $display("FAIL merge_third: got a=%h s=%b v=%b want 00002004 1000 1", wr_req_addr_o, wr_req_strb_o, wr_req_valid_o); end
        wr_req_ready_i = 1'b1;
        tick();
        wr_req_ready_i = 1'b0;
        wr_resp_valid_i = 1'b1;
        tick();
        wr_resp_valid_i = 1'b0;
        checks++; if (drain_cnt_o !== 16'd2) begin failures++; $display("FAIL merge_cnt: got %0d want 2", drain_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_drop();
        test_error();
        test_stray_resp();
        test_reset_mid();
`ifdef STORE_DRAIN_MERGE_EN
        test_merge();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
